// File: rtl/mux_sweep_checker.sv
// Stimulus sequencer and checker for 2:1 mux variants: sweeps all eight
// {sel,in0,in1} vectors, compares up to three mux outputs, reports a verdict.
module mux_sweep_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int NUM_DUT     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               sel,
  output logic               in0,
  output logic               in1,
  input  logic [NUM_DUT-1:0] dut_out,
  output logic [2:0]         vec_idx,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [4:0]         err_cnt,
  output logic [NUM_DUT-1:0] err_mask
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [1:0] popcount(input logic [NUM_DUT-1:0] bits);
    logic [1:0] acc;
    acc = 2'd0;
    for (int i = 0; i < NUM_DUT; i++) begin
      acc = acc + {1'b0, bits[i]};
    end
    return acc;
  endfunction

  state_t             state_r, state_nxt;
  logic [2:0]         vec_r, vec_nxt;
  logic [CW-1:0]      cnt_r, cnt_nxt;
  logic [4:0]         err_cnt_r, err_cnt_nxt;
  logic [NUM_DUT-1:0] err_mask_r, err_mask_nxt;
  logic               busy_r, busy_nxt;
  logic               done_r, done_nxt;
  logic               pass_r, pass_nxt;
  logic               exp_s;
  logic [NUM_DUT-1:0] mismatch_s;

  // The stimulus lines come straight from the vector register, so they only
  // change on a vector step and cannot glitch between vectors.
  assign sel      = vec_r[2];
  assign in0      = vec_r[1];
  assign in1      = vec_r[0];
  assign vec_idx  = vec_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign pass     = pass_r;
  assign err_cnt  = err_cnt_r;
  assign err_mask = err_mask_r;

  // Next-state, counters and next values of the registered status outputs.
  always_comb begin
    state_nxt    = state_r;
    vec_nxt      = vec_r;
    cnt_nxt      = cnt_r;
    err_cnt_nxt  = err_cnt_r;
    err_mask_nxt = err_mask_r;
    exp_s        = vec_r[2] ? vec_r[0] : vec_r[1];
    mismatch_s   = dut_out ^ {NUM_DUT{exp_s}};
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt    = ST_DRIVE;
          vec_nxt      = 3'd0;
          cnt_nxt      = HOLD_LOAD;
          err_cnt_nxt  = 5'd0;
          err_mask_nxt = {NUM_DUT{1'b0}};
        end else begin
          state_nxt = state_r;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt = ST_SAMPLE;
        end else begin
          cnt_nxt = cnt_r - CW'(1);
        end
      end
      ST_SAMPLE: begin
        // At most 3 mismatches per vector over 8 vectors, so 5 bits never wrap.
        err_cnt_nxt  = err_cnt_r + {3'b000, popcount(mismatch_s)};
        err_mask_nxt = err_mask_r | mismatch_s;
        if (vec_r == 3'd7) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_DRIVE;
          vec_nxt   = vec_r + 3'd1;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt == ST_DRIVE) || (state_nxt == ST_SAMPLE);
    done_nxt = (state_nxt == ST_DONE);
    pass_nxt = done_nxt && (err_cnt_nxt == 5'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      vec_r      <= 3'd0;
      cnt_r      <= {CW{1'b0}};
      err_cnt_r  <= 5'd0;
      err_mask_r <= {NUM_DUT{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      vec_r      <= vec_nxt;
      cnt_r      <= cnt_nxt;
      err_cnt_r  <= err_cnt_nxt;
      err_mask_r <= err_mask_nxt;
      busy_r     <= busy_nxt;
      done_r     <= done_nxt;
      pass_r     <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: instance 0 uses defaults, instance 1 uses
// HOLD_CYCLES=1 / NUM_DUT=2; both drive behavioural (optionally faulty) muxes.
module tb_mux_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v;
  logic [1:0] start_v;
  logic [2:0] mode [3];

  logic       sel_a, in0_a, in1_a, busy_a, done_a, pass_a;
  logic [2:0] dut_a, vec_a, mask_a;
  logic [4:0] cnt_a;
  logic       sel_b, in0_b, in1_b, busy_b, done_b, pass_b;
  logic [1:0] dut_b, mask_b;
  logic [2:0] vec_b;
  logic [4:0] cnt_b;

  // mode: 0 ideal, 1 stuck-0, 2 inverted, 3 select swapped, 4 stuck-1
  function automatic logic mux_model(input logic [2:0] m, input logic s, input logic a, input logic b);
    case (m)
      3'd1:    return 1'b0;
      3'd2:    return ~(s ? b : a);
      3'd3:    return s ? a : b;
      3'd4:    return 1'b1;
      default: return s ? b : a;
    endcase
  endfunction

  assign dut_a = {mux_model(mode[2], sel_a, in0_a, in1_a),
                  mux_model(mode[1], sel_a, in0_a, in1_a),
                  mux_model(mode[0], sel_a, in0_a, in1_a)};
  assign dut_b = {mux_model(mode[1], sel_b, in0_b, in1_b),
                  mux_model(mode[0], sel_b, in0_b, in1_b)};

  mux_sweep_checker #(.HOLD_CYCLES(4), .NUM_DUT(3)) u_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
    .sel(sel_a), .in0(in0_a), .in1(in1_a), .dut_out(dut_a),
    .vec_idx(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(cnt_a), .err_mask(mask_a)
  );

  mux_sweep_checker #(.HOLD_CYCLES(1), .NUM_DUT(2)) u_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
    .sel(sel_b), .in0(in0_b), .in1(in1_b), .dut_out(dut_b),
    .vec_idx(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(cnt_b), .err_mask(mask_b)
  );

  logic [1:0] busy_v, done_v, pass_v;
  logic [2:0] vec_v  [2];
  logic [2:0] stim_v [2];
  logic [2:0] mask_v [2];
  logic [4:0] cnt_v  [2];
  assign busy_v    = {busy_b, busy_a};
  assign done_v    = {done_b, done_a};
  assign pass_v    = {pass_b, pass_a};
  assign vec_v[0]  = vec_a;
  assign vec_v[1]  = vec_b;
  assign stim_v[0] = {sel_a, in0_a, in1_a};
  assign stim_v[1] = {sel_b, in0_b, in1_b};
  assign mask_v[0] = mask_a;
  assign mask_v[1] = {1'b0, mask_b};
  assign cnt_v[0]  = cnt_a;
  assign cnt_v[1]  = cnt_b;

  int checks = 0;
  int errors = 0;
  int         last_cnt  [2];
  logic [2:0] last_mask [2];
  logic [1:0] in_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_modes(input logic [2:0] m0, input logic [2:0] m1, input logic [2:0] m2);
    mode[0] = m0;
    mode[1] = m1;
    mode[2] = m2;
  endtask

  task automatic check_reset_state(input int w);
    check_eq("rst_busy", 32'(busy_v[w]), 32'd0);
    check_eq("rst_done", 32'(done_v[w]), 32'd0);
    check_eq("rst_pass", 32'(pass_v[w]), 32'd0);
    check_eq("rst_cnt",  32'(cnt_v[w]),  32'd0);
    check_eq("rst_mask", 32'(mask_v[w]), 32'd0);
    check_eq("rst_vec",  32'(vec_v[w]),  32'd0);
    check_eq("rst_stim", 32'(stim_v[w]), 32'd0);
  endtask

  task automatic do_reset(input int w);
    @(negedge clk);
    rst_v[w]   = 1'b1;
    start_v[w] = 1'b0;
    @(negedge clk);
    check_reset_state(w);
    rst_v[w]   = 1'b0;
    in_done[w] = 1'b0;
  endtask

  // One full sweep from a start pulse; expectations come from enumerating the
  // eight vectors against the mux models and from the cycle arithmetic.
  task automatic run_sweep(input int w, input bit extra, input bit keep_start);
    int         hold;
    int         nd;
    int         done_k;
    int         pulse_k;
    int         exp_cnt;
    logic [2:0] exp_mask;
    hold     = (w == 0) ? 4 : 1;
    nd       = (w == 0) ? 3 : 2;
    done_k   = 1 + 8 * (hold + 1);
    pulse_k  = extra ? int'($urandom_range(1, done_k - 1)) : -1;
    exp_cnt  = 0;
    exp_mask = 3'b000;
    for (int v = 0; v < 8; v++) begin
      logic s, a, b, e;
      s = v[2];
      a = v[1];
      b = v[0];
      e = s ? b : a;
      for (int i = 0; i < nd; i++) begin
        if (mux_model(mode[i], s, a, b) != e) begin
          exp_cnt++;
          exp_mask[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
    start_v[w] = 1'b1;
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk);
      if (!keep_start) start_v[w] = (k == pulse_k);
      if (k < done_k) begin
        check_eq("run_busy", 32'(busy_v[w]), 32'd1);
        check_eq("run_done", 32'(done_v[w]), 32'd0);
        check_eq("run_vec",  32'(vec_v[w]),  32'((k - 1) / (hold + 1)));
        check_eq("run_stim", 32'(stim_v[w]), 32'((k - 1) / (hold + 1)));
        if (k == 1) begin
          check_eq("start_clr_cnt",  32'(cnt_v[w]),  32'd0);
          check_eq("start_clr_mask", 32'(mask_v[w]), 32'd0);
        end
      end else begin
        check_eq("end_done", 32'(done_v[w]), 32'd1);
        check_eq("end_busy", 32'(busy_v[w]), 32'd0);
        check_eq("end_cnt",  32'(cnt_v[w]),  32'(exp_cnt));
        check_eq("end_mask", 32'(mask_v[w]), 32'(exp_mask));
        check_eq("end_pass", 32'(pass_v[w]), 32'(exp_cnt == 0));
        check_eq("end_stim", 32'(stim_v[w]), 32'd7);
      end
    end
    last_cnt[w]  = exp_cnt;
    last_mask[w] = exp_mask;
    in_done[w]   = 1'b1;
    if (keep_start) begin
      @(negedge clk);
      check_eq("rerun_done", 32'(done_v[w]), 32'd0);
      check_eq("rerun_busy", 32'(busy_v[w]), 32'd1);
      check_eq("rerun_vec",  32'(vec_v[w]),  32'd0);
      check_eq("rerun_cnt",  32'(cnt_v[w]),  32'd0);
      start_v[w] = 1'b0;
      in_done[w] = 1'b0;
    end
  endtask

  // Results must stay frozen while parked in DONE, even if the muxes change.
  task automatic idle_check(input int w, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (in_done[w]) begin
        check_eq("hold_done", 32'(done_v[w]), 32'd1);
        check_eq("hold_cnt",  32'(cnt_v[w]),  32'(last_cnt[w]));
        check_eq("hold_mask", 32'(mask_v[w]), 32'(last_mask[w]));
      end
    end
  endtask

  task automatic rst_mid(input int w);
    int hold;
    int k_r;
    hold = (w == 0) ? 4 : 1;
    k_r  = 1 + 3 * (hold + 1) + int'($urandom_range(0, hold));
    @(negedge clk);
    start_v[w] = 1'b1;
    for (int k = 1; k <= k_r; k++) begin
      @(negedge clk);
      start_v[w] = 1'b0;
    end
    check_eq("mid_vec", 32'(vec_v[w]), 32'd3);
    rst_v[w] = 1'b1;
    @(negedge clk);
    check_reset_state(w);
    rst_v[w]   = 1'b0;
    in_done[w] = 1'b0;
  endtask

  task automatic rst_with_start(input int w);
    @(negedge clk);
    rst_v[w]   = 1'b1;
    start_v[w] = 1'b1;
    @(negedge clk);
    check_reset_state(w);
    rst_v[w]   = 1'b0;
    start_v[w] = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 32'(busy_v[w]), 32'd0);
    check_eq("idle_done", 32'(done_v[w]), 32'd0);
    in_done[w] = 1'b0;
  endtask

  initial begin
    rst_v   = 2'b11;
    start_v = 2'b00;
    in_done = 2'b00;
    set_modes(3'd0, 3'd0, 3'd0);
    repeat (3) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    rst_v = 2'b00;

    run_sweep(0, 1'b0, 1'b0);
    set_modes(3'd0, 3'd1, 3'd0);
    run_sweep(0, 1'b0, 1'b0);
    set_modes(3'd0, 3'd1, 3'd2);
    idle_check(0, 3);
    run_sweep(0, 1'b1, 1'b0);
    set_modes(3'd3, 3'd0, 3'd0);
    run_sweep(0, 1'b0, 1'b0);
    set_modes(3'd0, 3'd1, 3'd2);
    rst_mid(0);
    set_modes(3'd0, 3'd0, 3'd0);
    run_sweep(0, 1'b0, 1'b0);
    run_sweep(0, 1'b0, 1'b1);
    do_reset(0);
    rst_with_start(0);

    run_sweep(1, 1'b0, 1'b0);
    set_modes(3'd3, 3'd2, 3'd0);
    run_sweep(1, 1'b1, 1'b0);
    rst_mid(1);

    for (int r = 0; r < 12; r++) begin
      int w;
      w = int'($urandom_range(0, 1));
      set_modes(3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)));
      idle_check(w, int'($urandom_range(0, 3)));
      run_sweep(w, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_sweep_checker.md
# mux_sweep_checker

Self-checking stimulus sequencer for the 2:1 multiplexer variants in the practice03 stage. The block drives the shared `sel`/`in0`/`in1` lines through all eight input combinations in order, holds each one for a configurable settle time, samples up to three mux outputs, and compares each output against the expected value `sel ? in1 : in0`. It sits directly upstream of the muxes, because it feeds their inputs. It also sits directly downstream of them, because it consumes their outputs. It reports a pass/fail verdict, an error count and a per-DUT error mask, which lets the mux exercise run on hardware without a simulator console.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: number of cycles each vector is driven before it is sampled. Legal range is at least 1.
- `NUM_DUT`, default 3: number of mux outputs checked. Legal range is 1 to 3.

Ports:
- `clk`, input, 1 bit: single clock. All logic is clocked on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `start`, input, 1 bit: sampled in IDLE or DONE and starts a sweep. It is ignored while `busy`=1.
- `sel`, output, 1 bit: registered mux select stimulus.
- `in0`, output, 1 bit: registered mux data-0 stimulus.
- `in1`, output, 1 bit: registered mux data-1 stimulus.
- `dut_out`, input, `NUM_DUT` bits: mux outputs. Bit i is DUT i.
- `vec_idx`, output, 3 bits: current vector, equal to {sel,in0,in1}.
- `busy`, output, 1 bit: high in DRIVE and SAMPLE.
- `done`, output, 1 bit: high in DONE.
- `pass`, output, 1 bit: `done` and `err_cnt`==0.
- `err_cnt`, output, 5 bits: total mismatches over all vectors and all DUTs. The maximum is 24.
- `err_mask`, output, `NUM_DUT` bits: sticky flags. Bit i is set once DUT i has mismatched at least once.

## Operation
- The FSM has four states: IDLE, DRIVE, SAMPLE and DONE.
- IDLE:
  - Stimulus is held at 000.
  - When `start`=1, the block clears `err_cnt` and `err_mask`, sets `vec_idx`=0, loads the hold counter with `HOLD_CYCLES`-1, and moves to DRIVE.
- DRIVE:
  - {sel,in0,in1} = `vec_idx`, held stable.
  - The hold counter decrements each cycle. When the counter is 0, the FSM moves to SAMPLE.
- SAMPLE (one cycle):
  - Compute exp = sel ? in1 : in0 and mismatch[i] = dut_out[i] ^ exp.
  - Add popcount(mismatch) to `err_cnt`.
  - OR mismatch into `err_mask`.
  - If `vec_idx`==7, move to DONE.
  - Otherwise, increment `vec_idx`, reload the hold counter, and move to DRIVE.
- DONE:
  - Stimulus holds the last vector (111).
  - `done`=1. `err_cnt` and `err_mask` are frozen.
  - `start`=1 behaves exactly as in IDLE (counters cleared, move to DRIVE).
- Stimulus stays unchanged from the first DRIVE cycle of a vector through its SAMPLE cycle. There are no glitches between vectors.
- `err_cnt` never wraps, because 5 bits covers 8×3.
- Reset values: `sel`, `in0`, `in1` = 0; `vec_idx` = 0; `busy`, `done`, `pass` = 0; `err_cnt` = 0; `err_mask` = 0; state = IDLE.

## Timing
- `start` is seen at edge T:
  - From cycle T+1: `busy`=1 and vector 000 is on the outputs.
- Each vector occupies `HOLD_CYCLES`+1 cycles. The comparison uses `dut_out` in the SAMPLE cycle, and the result is registered at the end of that cycle.
- `done` rises at cycle T+1+8×(`HOLD_CYCLES`+1). With the defaults, that is T+41.
- `busy` falls in the same cycle that `done` rises.
- `pass` is valid only while `done`=1.
- `rst` asserted in any state, including mid-sweep or during SAMPLE: at the next edge every output returns to its reset value. Any partial count in progress is discarded.
- `rst` and `start` in the same cycle: reset wins, and the state is IDLE afterwards.
- `start` held high continuously: a new sweep begins on the cycle after DONE is entered. That means `done` is high for exactly one cycle before counters clear.
- The DUTs are combinational, so one settle cycle is enough. `HOLD_CYCLES`=1 must produce identical verdicts.

## Test plan
- Ideal mux models on all 3 DUTs, `start` pulse at T → `done`=1 at T+41, `pass`=1, `err_cnt`=0, `err_mask`=000. `vec_idx` steps 0 to 7 every 5 cycles.
- DUT1 stuck at 0 → mismatches at vectors 010, 011, 101 and 111. Result: `err_cnt`=4, `err_mask`=010, `pass`=0.
- DUT1 stuck at 0 and DUT2 inverted → `err_cnt`=12, `err_mask`=110.
- DUT0 with select polarity swapped (out = sel ? in0 : in1) → mismatches at 001, 010, 101 and 110. Result: `err_cnt`=4, `err_mask`=001.
- Mismatch scenario, then `rst` at `vec_idx`=3 → next cycle: all outputs 0, state IDLE. A fresh `start` with ideal DUTs then completes with `pass`=1.
- Extra `start` pulses while `busy` → no effect: same timing, done at T+41. `start` in DONE after a failing run → counters clear and `done`=0 on the next cycle. A rerun with ideal DUTs gives `pass`=1. `HOLD_CYCLES`=1 → `done` at T+17.
